// File: rtl/mult_pkg.sv
// Shared multiplier definitions: default operand width and the
// control FSM state encoding used by the controller, accumulator and adder.
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter width for an iteration count of w, never less than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the shift-add multiplier: cleared on load,
// advanced on each shift, flags the final iteration.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // Count completed shifts; the increment after LAST only happens on the
    // way into DONE, so the wrap is never observed mid-operation.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mult_ctrl.sv
// Shift-add multiplier controller: sequences load, add and shift pulses
// for the accumulator and reports Busy/Done with a level St handshake.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic rst,
    input  logic St,
    input  logic M,
    output logic Load,
    output logic Ad,
    output logic Sh,
    output logic Busy,
    output logic Done
);

    state_t state;
    logic   load_r;
    logic   busy_r;
    logic   done_r;
    logic   shift_r;
    logic   in_test;
    logic   tc;

    mult_iter_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .Clk(Clk),
        .rst(rst),
        .clr(state == LOAD),
        .en (Sh),
        .tc (tc)
    );

    // State register plus outputs that depend on the state alone.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            shift_r <= 1'b0;
        end else begin
            load_r  <= 1'b0;
            shift_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (St) begin
                        state  <= LOAD;
                        load_r <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= TEST;
                end
                TEST: begin
                    if (M) begin
                        state   <= SHIFT;
                        shift_r <= 1'b1;
                    end else if (tc) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tc) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        state <= TEST;
                    end
                end
                DONE: begin
                    if (!St) begin
                        state  <= IDLE;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // In TEST the multiplier bit picks add or shift within the same cycle.
    always_comb begin
        in_test = (state == TEST);
        Ad      = in_test & M;
        Sh      = shift_r | (in_test & ~M);
    end

    assign Load = load_r;
    assign Busy = busy_r;
    assign Done = done_r;

endmodule
